// File: rtl/ysyx_24100005_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24100005_wb_pkg : shared types for the writeback arbiter         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ysyx_24100005_wb_pkg;

  // Arbiter pointer: records which requester was granted most recently
  typedef enum logic [0:0] {
    LAST_EXU = 1'b0,
    LAST_LSU = 1'b1
  } ptr_e;

  localparam logic [0:0] REQ_EXU = 1'b0;
  localparam logic [0:0] REQ_LSU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100005_Scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24100005_Scoreboard : pending-write bitmap, set wins over clear  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ysyx_24100005_Scoreboard #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_en,
  input  logic [ADDR_WIDTH-1:0]      set_idx,
  input  logic                       clr_en,
  input  logic [ADDR_WIDTH-1:0]      clr_idx,
  output logic [2**ADDR_WIDTH-1:0]   busy
);

  logic [2**ADDR_WIDTH-1:0] busy_d;
  logic [2**ADDR_WIDTH-1:0] busy_q;

  // Clear is applied first so a same-index set (newer producer) overrides it
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_24100005_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24100005_wb_arbiter : round-robin EXU/LSU writeback arbiter      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ysyx_24100005_wb_arbiter
  import ysyx_24100005_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exu_valid,
  output logic                       exu_ready,
  input  logic [ADDR_WIDTH-1:0]      exu_rd,
  input  logic [DATA_WIDTH-1:0]      exu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [2**ADDR_WIDTH-1:0]   busy,
  input  logic [ADDR_WIDTH-1:0]      rs1,
  input  logic [ADDR_WIDTH-1:0]      rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy
);

  ptr_e                  ptr_d, ptr_q;
  logic                  grant;
  logic [0:0]            gnt_id;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  rf_wen_d, rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_d, rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_d, rf_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= LAST_LSU;
    else      ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (exu_ready)      ptr_d = LAST_EXU;
    else if (lsu_ready) ptr_d = LAST_LSU;
  end

  // On a tie, the requester that did not win last time is served
  always_comb begin
    exu_ready = exu_valid && (!lsu_valid || (ptr_q == LAST_LSU));
    lsu_ready = lsu_valid && (!exu_valid || (ptr_q == LAST_EXU));
  end

  assign grant    = exu_ready || lsu_ready;
  assign gnt_id   = lsu_ready ? REQ_LSU : REQ_EXU;
  assign sel_rd   = (gnt_id == REQ_LSU) ? lsu_rd   : exu_rd;
  assign sel_data = (gnt_id == REQ_LSU) ? lsu_data : exu_data;

  // Writes to x0 are accepted but never reach the register file
  always_comb begin
    rf_wen_d   = grant && (sel_rd != '0);
    rf_waddr_d = rf_wen_d ? sel_rd   : rf_waddr_q;
    rf_wdata_d = rf_wen_d ? sel_data : rf_wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  ysyx_24100005_Scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_valid),
    .set_idx (iss_rd),
    .clr_en  (grant),
    .clr_idx (sel_rd),
    .busy    (busy)
  );

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_24100005_wb_arbiter : directed self-checking bench            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ysyx_24100005_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd = '0, lsu_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] exu_data = '0, lsu_data = '0;
  logic        rf_wen, rs1_busy, rs2_busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24100005_wb_arbiter #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic e, input logic l);
    #1;
    chk({tag, "_exu_ready"}, 64'(exu_ready), 64'(e));
    chk({tag, "_lsu_ready"}, 64'(lsu_ready), 64'(l));
    chk({tag, "_one_hot"}, 64'(exu_ready & lsu_ready), 64'd0);
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wen"},   64'(rf_wen),   64'(w));
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(a));
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
  endtask

  initial begin
    // Reset state
    #2;
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    step();
    rst = 1'b1;

    // Single EXU request
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    chk_ready("exu_only", 1'b1, 1'b0);
    step();
    exu_valid = 1'b0;
    chk_wr("exu_wr", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk_wr("exu_idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // Re-reset, then three cycles of tie: EXU, LSU, EXU
    rst = 1'b0;
    step();
    rst = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'hAAAA0001;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hBBBB0002;
    chk_ready("tie1", 1'b1, 1'b0);
    step();
    chk_wr("tie1_wr", 1'b1, 5'd1, 32'hAAAA0001);
    chk_ready("tie2", 1'b0, 1'b1);
    step();
    chk_wr("tie2_wr", 1'b1, 5'd2, 32'hBBBB0002);
    chk_ready("tie3", 1'b1, 1'b0);
    step();
    chk_wr("tie3_wr", 1'b1, 5'd1, 32'hAAAA0001);
    exu_valid = 1'b0; lsu_valid = 1'b0;

    // Issue rd=7, EXU writeback two cycles later
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    step();
    iss_valid = 1'b0;
    chk("sb7_c1", 64'(busy[7]), 64'd1);
    chk("sb7_rs1_c1", 64'(rs1_busy), 64'd1);
    step();
    chk("sb7_c2", 64'(busy[7]), 64'd1);
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h00000077;
    chk_ready("sb7_wb", 1'b1, 1'b0);
    chk("sb7_nobypass", 64'(rs1_busy), 64'd1);
    step();
    exu_valid = 1'b0;
    chk("sb7_clr", 64'(busy[7]), 64'd0);
    chk("sb7_rs1_clr", 64'(rs1_busy), 64'd0);
    chk_wr("sb7_wr", 1'b1, 5'd7, 32'h00000077);

    // Set beats clear on the same index
    iss_valid = 1'b1; iss_rd = 5'd3; rs2 = 5'd3;
    step();
    chk("sb3_set", 64'(busy), 64'h8);
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h00003333;
    chk_ready("sb3_both", 1'b0, 1'b1);
    chk("sb3_rs2", 64'(rs2_busy), 64'd1);
    step();
    iss_valid = 1'b0; lsu_valid = 1'b0;
    chk("sb3_setwins", 64'(busy[3]), 64'd1);
    chk_wr("sb3_wr", 1'b1, 5'd3, 32'h00003333);

    // Writeback and issue to x0
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h00001234;
    iss_valid = 1'b1; iss_rd = 5'd0;
    chk_ready("x0", 1'b1, 1'b0);
    step();
    exu_valid = 1'b0; iss_valid = 1'b0;
    chk("x0_wen", 64'(rf_wen), 64'd0);
    chk("x0_busy", 64'(busy), 64'h8);

    // Async reset with a write in flight and busy=0x88
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h00000044;
    step();
    exu_valid = 1'b0;
    chk_wr("pre_rst", 1'b1, 5'd4, 32'h00000044);
    chk("pre_rst_busy", 64'(busy), 64'h88);
    #2;
    rst = 1'b0;
    #1;
    chk_wr("async_rst", 1'b0, 5'd0, 32'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_rs1", 64'(rs1_busy), 64'd0);
    step();
    rst = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd9;  exu_data = 32'h00000099;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h000000AA;
    chk_ready("post_rst_tie", 1'b1, 1'b0);
    step();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    chk_wr("post_rst_wr", 1'b1, 5'd9, 32'h00000099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_24100005_wb_arbiter.md
YSYX_24100005_WB_ARBITER -- requirements
Module: ysyx_24100005_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports exu_valid in 1, exu_ready out 1, exu_rd in ADDR_WIDTH, exu_data in DATA_WIDTH: EXU writeback request.
REQ-006 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_rd in ADDR_WIDTH, lsu_data in DATA_WIDTH: LSU load writeback request.
REQ-007 SHALL have ports iss_valid in 1, iss_rd in ADDR_WIDTH: instruction issued with destination rd.
REQ-008 SHALL have ports rf_wen out 1, rf_waddr out ADDR_WIDTH, rf_wdata out DATA_WIDTH: register-file write port.
REQ-009 SHALL have port busy out 2**ADDR_WIDTH: pending-write bitmap, bit n = register n awaiting writeback.
REQ-010 SHALL have ports rs1, rs2 in ADDR_WIDTH; rs1_busy, rs2_busy out 1: hazard query.

Function
REQ-011 Transfer SHALL occur when valid && ready in the same cycle; ready depends combinationally on both valids and the pointer state only; requester SHALL hold rd/data stable while valid && !ready.
REQ-012 At most one ready SHALL be high per cycle; single valid requester SHALL be granted that cycle.
REQ-013 Both valid: grant SHALL go to the requester not granted last; pointer FSM states LAST_EXU, LAST_LSU.
REQ-014 Pointer SHALL change only on a grant: EXU grant -> LAST_EXU, LSU grant -> LAST_LSU; no grant -> hold.
REQ-015 Write port SHALL be registered: grant at edge N -> rf_wen=1, rf_waddr=rd, rf_wdata=data for cycle N+1 only; no grant -> rf_wen=0 (waddr/wdata hold).
REQ-016 Grant with rd==0 SHALL be accepted (ready=1) but SHALL NOT raise rf_wen and SHALL NOT touch busy.
REQ-017 iss_valid && iss_rd!=0 SHALL set busy[iss_rd] at next edge.
REQ-018 Grant with rd!=0 SHALL clear busy[rd] at next edge (same edge the write is registered).
REQ-019 Set and clear of same index same cycle: set SHALL win (newer producer pending).
REQ-020 busy[0] SHALL be constant 0.
REQ-021 rs1_busy = busy[rs1], rs2_busy = busy[rs2], combinational from registered busy (no same-cycle bypass of clear).
REQ-022 Data SHALL pass unmodified; no width conversion.

Reset
REQ-023 rst low SHALL asynchronously force rf_wen=0, rf_waddr=0, rf_wdata=0, busy=all 0, pointer=LAST_LSU (EXU wins first tie).
REQ-024 Reset mid-transfer SHALL drop the registered write; rf_wen falls immediately on rst assertion.
REQ-025 First grant SHALL be possible at first rising edge after rst deasserts.

Structure
REQ-026 Package ysyx_24100005_wb_pkg SHALL hold the pointer-state enum and requester ID constants REQ_EXU=0, REQ_LSU=1.
REQ-027 Scoreboard SHALL be sub-module ysyx_24100005_Scoreboard (set/clear ports, busy vector, async active-low reset); existing sync-reset register template SHALL NOT be used here.

Verification
REQ-028 Reset release, EXU only valid rd=5 data=0xDEADBEEF -> exu_ready=1, next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF, then rf_wen=0.
REQ-029 Both valid 3 consecutive cycles after reset -> grants EXU, LSU, EXU; ready never both high.
REQ-030 iss rd=7 then EXU writeback rd=7 two cycles later -> busy[7] 1 for 2 cycles then 0; rs1=7 reads rs1_busy matching.
REQ-031 Same cycle iss rd=3 and LSU grant rd=3 with busy[3]=1 -> busy[3] stays 1, rf_wen=1 waddr=3.
REQ-032 EXU grant rd=0 data=0x1234 -> exu_ready=1, rf_wen stays 0, busy unchanged; iss rd=0 -> busy[0]=0.
REQ-033 Assert rst mid-cycle while rf_wen=1 and busy=0x88 -> rf_wen, busy, outputs 0 immediately; after release tie grants EXU.
